// File: rtl/uart_tx_scheduler_if.sv
// Bundle between the two byte requesters, the uart_tx byte transmitter
// and the scheduler that shares it.
//   req0_valid/req0_data/req0_ready : requester 0 byte push handshake
//   req1_valid/req1_data/req1_ready : requester 1 byte push handshake
//   tx_dv/tx_byte                   : start pulse and byte toward uart_tx
//   tx_active/tx_done               : status back from uart_tx
//   busy/grant_id/tx_error          : scheduler status
// The scheduler uses modport slave; the requester/transmitter side uses master.
interface uart_tx_scheduler_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_active;
    logic       tx_done;
    logic       busy;
    logic       grant_id;
    logic       tx_error;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, tx_active, tx_done,
        output req0_ready, req1_ready, tx_dv, tx_byte, busy, grant_id, tx_error
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, tx_active, tx_done,
        input  req0_ready, req1_ready, tx_dv, tx_byte, busy, grant_id, tx_error
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx byte transmitter between two requesters. Each requester
// owns a DEPTH-entry byte FIFO; a round-robin scheduler sends one byte per
// grant, waits for tx_done (or a timeout) and then an inter-byte gap.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : uart_tx_scheduler_if.slave (requester handshakes, uart_tx handshake,
//          busy / grant_id / sticky tx_error status)
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | waiting for a queued byte while uart_tx is not active
// S_START     | tx_dv high for this single cycle, byte on tx_byte
// S_WAIT_DONE | waiting for tx_done; aborts after TIMEOUT cycles
// S_GAP       | GAP_CYCLES idle cycles before the next grant
module uart_tx_scheduler #(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 65535
) (
    input logic                clk,
    input logic                rst,
    uart_tx_scheduler_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t        FULL     = cnt_t'(DEPTH);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t      state;
    logic [7:0]  mem0 [DEPTH];
    logic [7:0]  mem1 [DEPTH];
    ptr_t        wr0, rd0, wr1, rd1;
    cnt_t        cnt0, cnt1;
    logic        tx_dv_q;
    logic [7:0]  tx_byte_q;
    logic        grant_q;
    logic        err_q;
    logic [15:0] to_cnt;
    logic [15:0] gap_cnt;

    logic ne0, ne1;
    logic push0, push1;
    logic launch, sel, pop0, pop1;

    assign ne0   = (cnt0 != '0);
    assign ne1   = (cnt1 != '0);
    // Ready comes from the registered count only, so a same-cycle pop never
    // opens a full FIFO early.
    assign push0 = bus.req0_valid && (cnt0 != FULL);
    assign push1 = bus.req1_valid && (cnt1 != FULL);

    // Tie goes to the requester that was not served last; grant_q resets to 1
    // so requester 0 wins the very first tie.
    assign launch = (state == S_IDLE) && !bus.tx_active && (ne0 || ne1);
    assign sel    = (ne0 && ne1) ? ~grant_q : ~ne0;
    assign pop0   = launch && !sel;
    assign pop1   = launch && sel;

    always_ff @(posedge clk) begin
        if (push0) mem0[wr0] <= bus.req0_data;
        if (push1) mem1[wr1] <= bus.req1_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr0  <= '0;
            rd0  <= '0;
            cnt0 <= '0;
            wr1  <= '0;
            rd1  <= '0;
            cnt1 <= '0;
        end else begin
            if (push0) wr0 <= wr0 + ptr_t'(1);
            if (pop0)  rd0 <= rd0 + ptr_t'(1);
            if (push1) wr1 <= wr1 + ptr_t'(1);
            if (pop1)  rd1 <= rd1 + ptr_t'(1);
            cnt0 <= cnt0 + cnt_t'(push0) - cnt_t'(pop0);
            cnt1 <= cnt1 + cnt_t'(push1) - cnt_t'(pop1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
            grant_q   <= 1'b1;
            err_q     <= 1'b0;
            to_cnt    <= '0;
            gap_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        tx_byte_q <= sel ? mem1[rd1] : mem0[rd0];
                        grant_q   <= sel;
                        tx_dv_q   <= 1'b1;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    tx_dv_q <= 1'b0;
                    to_cnt  <= '0;
                    state   <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (bus.tx_done) begin
                        if (GAP_CYCLES == 0) begin
                            state <= S_IDLE;
                        end else begin
                            gap_cnt <= GAP_LAST;
                            state   <= S_GAP;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        // Abort after TIMEOUT cycles in this state; the byte is dropped.
                        err_q <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req0_ready = (cnt0 != FULL);
    assign bus.req1_ready = (cnt1 != FULL);
    assign bus.tx_dv      = tx_dv_q;
    assign bus.tx_byte    = tx_byte_q;
    assign bus.grant_id   = grant_q;
    assign bus.tx_error   = err_q;
    assign bus.busy       = (state != S_IDLE) || ne0 || ne1;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler. Instance a: GAP_CYCLES=16, TIMEOUT=100;
// instance b: GAP_CYCLES=0, TIMEOUT=100. A queue-based transaction model of
// both instances is compared against every output on every cycle, and the
// directed scenarios pin exact latencies, orders and reset values.
module tb_uart_tx_scheduler;
    localparam int DEPTH = 4;
    localparam int TO    = 100;
    localparam int FRAME = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    initial forever #5 clk = ~clk;

    uart_tx_scheduler_if a_if ();
    uart_tx_scheduler_if b_if ();

    uart_tx_scheduler #(.DEPTH(DEPTH), .GAP_CYCLES(16), .TIMEOUT(TO)) dut_a (
        .clk(clk), .rst(rst), .bus(a_if)
    );
    uart_tx_scheduler #(.DEPTH(DEPTH), .GAP_CYCLES(0), .TIMEOUT(TO)) dut_b (
        .clk(clk), .rst(rst), .bus(b_if)
    );

    logic [1:0] v0 = '0, v1 = '0, hold = '0, resp_en = 2'b11;
    logic [1:0] r_act = '0, r_done = '0;
    logic [1:0] act_in;
    logic [7:0] d0 [2];
    logic [7:0] d1 [2];
    logic [1:0] o_dv, o_r0, o_r1, o_busy, o_grant, o_err;
    logic [7:0] o_byte [2];

    assign act_in = r_act | hold;

    assign a_if.req0_valid = v0[0];
    assign a_if.req0_data  = d0[0];
    assign a_if.req1_valid = v1[0];
    assign a_if.req1_data  = d1[0];
    assign a_if.tx_active  = act_in[0];
    assign a_if.tx_done    = r_done[0];
    assign b_if.req0_valid = v0[1];
    assign b_if.req0_data  = d0[1];
    assign b_if.req1_valid = v1[1];
    assign b_if.req1_data  = d1[1];
    assign b_if.tx_active  = act_in[1];
    assign b_if.tx_done    = r_done[1];

    assign o_dv     = {b_if.tx_dv, a_if.tx_dv};
    assign o_r0     = {b_if.req0_ready, a_if.req0_ready};
    assign o_r1     = {b_if.req1_ready, a_if.req1_ready};
    assign o_busy   = {b_if.busy, a_if.busy};
    assign o_grant  = {b_if.grant_id, a_if.grant_id};
    assign o_err    = {b_if.tx_error, a_if.tx_error};
    assign o_byte[0] = a_if.tx_byte;
    assign o_byte[1] = b_if.tx_byte;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit armed = 1'b0;

    int         a_dv_cyc [$];
    logic [7:0] a_dv_byte [$];
    logic       a_dv_grant [$];
    int         b_dv_cyc [$];
    int         a_done_cyc [$];
    int         b_done_cyc [$];
    int         a_err_cyc = -1;

    // Model: FIFO contents as queues (index 2*inst+port) plus the phase of the
    // shared transmitter slot expressed as cycles waited / gap cycles left.
    logic [7:0] mq [4][$];
    bit         m_dv [2];
    int         m_wait [2];
    int         m_gap [2];
    logic [7:0] m_byte [2];
    bit         m_grant [2];
    bit         m_err [2];

    logic [7:0] t2_bytes [4] = '{8'h01, 8'h81, 8'h02, 8'h82};
    logic       t2_grant [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    function automatic int gap_of(input int i);
        return (i == 0) ? 16 : 0;
    endfunction

    task automatic model_reset(input int i);
        mq[2*i].delete();
        mq[2*i+1].delete();
        m_dv[i]    = 1'b0;
        m_wait[i]  = -1;
        m_gap[i]   = 0;
        m_byte[i]  = 8'h00;
        m_grant[i] = 1'b1;
        m_err[i]   = 1'b0;
    endtask

    task automatic model_check(input int i);
        bit idle;
        idle = !m_dv[i] && (m_wait[i] < 0) && (m_gap[i] == 0);
        chk($sformatf("tx_dv[%0d]", i), int'(o_dv[i]), int'(m_dv[i]));
        chk($sformatf("tx_byte[%0d]", i), int'(o_byte[i]), int'(m_byte[i]));
        chk($sformatf("grant_id[%0d]", i), int'(o_grant[i]), int'(m_grant[i]));
        chk($sformatf("tx_error[%0d]", i), int'(o_err[i]), int'(m_err[i]));
        chk($sformatf("req0_ready[%0d]", i), int'(o_r0[i]), int'(mq[2*i].size() != DEPTH));
        chk($sformatf("req1_ready[%0d]", i), int'(o_r1[i]), int'(mq[2*i+1].size() != DEPTH));
        chk($sformatf("busy[%0d]", i), int'(o_busy[i]),
            int'(!idle || mq[2*i].size() != 0 || mq[2*i+1].size() != 0));
    endtask

    task automatic model_step(input int i);
        bit idle, acc0, acc1, pick;
        int n0, n1;
        n0   = mq[2*i].size();
        n1   = mq[2*i+1].size();
        idle = !m_dv[i] && (m_wait[i] < 0) && (m_gap[i] == 0);
        acc0 = v0[i] && (n0 < DEPTH);
        acc1 = v1[i] && (n1 < DEPTH);
        if (idle) begin
            if (!act_in[i] && (n0 + n1 > 0)) begin
                pick       = (n0 > 0 && n1 > 0) ? !m_grant[i] : (n0 == 0);
                m_byte[i]  = mq[2*i+int'(pick)].pop_front();
                m_grant[i] = pick;
                m_dv[i]    = 1'b1;
            end
        end else if (m_dv[i]) begin
            m_dv[i]   = 1'b0;
            m_wait[i] = 0;
        end else if (m_wait[i] >= 0) begin
            if (r_done[i]) begin
                m_wait[i] = -1;
                m_gap[i]  = gap_of(i);
            end else if (m_wait[i] == TO - 1) begin
                m_err[i]  = 1'b1;
                m_wait[i] = -1;
            end else begin
                m_wait[i]++;
            end
        end else begin
            m_gap[i]--;
        end
        if (acc0) mq[2*i].push_back(d0[i]);
        if (acc1) mq[2*i+1].push_back(d1[i]);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Compare process: every cycle, both instances, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (armed) begin
            if (rst) begin
                if (o_dv[0]) begin
                    a_dv_cyc.push_back(cyc);
                    a_dv_byte.push_back(o_byte[0]);
                    a_dv_grant.push_back(o_grant[0]);
                end
                if (o_dv[1]) b_dv_cyc.push_back(cyc);
                if (r_done[0]) a_done_cyc.push_back(cyc);
                if (r_done[1]) b_done_cyc.push_back(cyc);
                if (o_err[0] && a_err_cyc < 0) a_err_cyc = cyc;
            end
            for (int i = 0; i < 2; i++) begin
                if (!rst) model_reset(i);
                model_check(i);
                if (rst) model_step(i);
            end
        end
    end

    // uart_tx stand-in: tx_dv in cycle S -> active S+1..S+FRAME, tx_done in S+1+FRAME.
    initial begin
        bit pend [2];
        int rcnt [2];
        rcnt[0] = 0;
        rcnt[1] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) pend[i] = o_dv[i] && resp_en[i];
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                r_done[i] = 1'b0;
                if (pend[i]) begin
                    rcnt[i]  = FRAME;
                    r_act[i] = 1'b1;
                end else if (rcnt[i] > 0) begin
                    rcnt[i]--;
                    if (rcnt[i] == 0) begin
                        r_act[i]  = 1'b0;
                        r_done[i] = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        armed = 1'b1;
        chk("rst_tx_dv", int'(o_dv[0]), 0);
        chk("rst_tx_byte", int'(o_byte[0]), 'h00);
        chk("rst_grant_id", int'(o_grant[0]), 1);
        chk("rst_tx_error", int'(o_err[0]), 0);
        chk("rst_req0_ready", int'(o_r0[0]), 1);
        chk("rst_req1_ready", int'(o_r1[0]), 1);
        chk("rst_busy", int'(o_busy[0]), 0);
        repeat (2) step();
        rst = 1'b1;
    endtask

    task automatic push(input int i, input int port, input logic [7:0] data, output int acc);
        logic rdy;
        if (port == 0) begin
            v0[i] = 1'b1;
            d0[i] = data;
        end else begin
            v1[i] = 1'b1;
            d1[i] = data;
        end
        acc = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            rdy = (port == 0) ? o_r0[i] : o_r1[i];
            if (rdy) begin
                acc = cyc;
                break;
            end
        end
        step();
        if (port == 0) v0[i] = 1'b0;
        else           v1[i] = 1'b0;
        if (acc < 0) bound_fail("push_accept");
    endtask

    task automatic wait_dv(input int i, input int n, input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (((i == 0) ? a_dv_cyc.size() : b_dv_cyc.size()) >= n) begin
                ok = 1'b1;
                break;
            end
        end
        step();
        if (!ok) begin
            bound_fail("wait_tx_dv");
            $display("FAIL wait_tx_dv: cannot continue");
            $fatal(1, "wait_tx_dv");
        end
    endtask

    task automatic wait_idle(input int i, input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!o_busy[i] && !act_in[i]) begin
                ok = 1'b1;
                break;
            end
        end
        step();
        if (!ok) bound_fail("wait_idle");
    endtask

    initial begin
        int c, base, dbase, td, bb;
        bit ok;
        d0[0] = 8'h00; d0[1] = 8'h00; d1[0] = 8'h00; d1[1] = 8'h00;

        // 1: single byte into an empty system -> tx_dv two cycles after accept
        do_reset();
        push(0, 0, 8'hA5, c);
        wait_dv(0, 1, 20);
        chk("t1_latency", a_dv_cyc[0] - c, 2);
        chk("t1_byte", int'(a_dv_byte[0]), 'hA5);
        chk("t1_grant", int'(a_dv_grant[0]), 0);
        wait_idle(0, 200);

        // 2: preloaded ties alternate, requester 0 first after reset
        do_reset();
        base = a_dv_cyc.size();
        hold[0] = 1'b1;
        step();
        push(0, 0, 8'h01, c);
        push(0, 0, 8'h02, c);
        push(0, 1, 8'h81, c);
        push(0, 1, 8'h82, c);
        hold[0] = 1'b0;
        wait_dv(0, base + 4, 400);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t2_byte%0d", k), int'(a_dv_byte[base+k]), int'(t2_bytes[k]));
            chk($sformatf("t2_grant%0d", k), int'(a_dv_grant[base+k]), int'(t2_grant[k]));
        end
        wait_idle(0, 200);

        // 3: requester 1 fills its FIFO while the transmitter is held busy
        base = a_dv_cyc.size();
        hold[0] = 1'b1;
        step();
        for (int k = 0; k < 4; k++) push(0, 1, 8'hC0 + 8'(k), c);
        v1[0] = 1'b1;
        d1[0] = 8'hC4;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t3_ready_full", int'(o_r1[0]), 0);
        end
        step();
        hold[0] = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (o_r1[0]) begin
                ok = 1'b1;
                break;
            end
        end
        step();
        v1[0] = 1'b0;
        if (!ok) bound_fail("t3_fifth_accept");
        wait_dv(0, base + 5, 600);
        for (int k = 0; k < 5; k++)
            chk($sformatf("t3_byte%0d", k), int'(a_dv_byte[base+k]), 'hC0 + k);
        wait_idle(0, 200);

        // 4: no tx_done -> abort after 100 cycles in WAIT_DONE, error sticks
        base = a_dv_cyc.size();
        resp_en[0] = 1'b0;
        push(0, 0, 8'h5A, c);
        push(0, 0, 8'h6B, c);
        wait_dv(0, base + 1, 20);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (a_err_cyc >= 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail("t4_error");
        else chk("t4_err_delay", a_err_cyc - a_dv_cyc[base], 101);
        wait_dv(0, base + 2, 50);
        chk("t4_next_spacing", a_dv_cyc[base+1] - a_dv_cyc[base], 102);
        chk("t4_next_byte", int'(a_dv_byte[base+1]), 'h6B);
        wait_idle(0, 300);
        chk("t4_err_sticky", int'(o_err[0]), 1);
        resp_en[0] = 1'b1;

        // 5: tx_done at T -> next tx_dv at T+18 (gap 16) / T+2 (gap 0)
        base  = a_dv_cyc.size();
        dbase = a_done_cyc.size();
        push(0, 0, 8'h11, c);
        push(0, 0, 8'h22, c);
        wait_dv(0, base + 2, 200);
        td = a_done_cyc[dbase];
        chk("t5_gap16", a_dv_cyc[base+1] - td, 18);
        chk("t5_gap16_byte", int'(a_dv_byte[base+1]), 'h22);
        bb = b_dv_cyc.size();
        dbase = b_done_cyc.size();
        push(1, 0, 8'h33, c);
        push(1, 0, 8'h44, c);
        wait_dv(1, bb + 2, 200);
        chk("t5_gap0", b_dv_cyc[bb+1] - b_done_cyc[dbase], 2);
        wait_idle(0, 200);
        wait_idle(1, 200);

        // 6: reset in WAIT_DONE with three bytes still queued
        hold[0] = 1'b1;
        step();
        for (int k = 0; k < 4; k++) push(0, 0, 8'h71 + 8'(k), c);
        hold[0] = 1'b0;
        base = a_dv_cyc.size();
        wait_dv(0, base + 1, 20);
        step();
        step();
        chk("t6_busy_before", int'(o_busy[0]), 1);
        do_reset();
        repeat (60) step();
        chk("t6_no_more_dv", a_dv_cyc.size(), base + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
